// File: rtl/key_event_tracker.sv
`default_nettype none
// ============================================================================
// Module      : key_event_tracker
// Description : Per-key hold/press/release/toggle tracking for a configurable
//               set of PS/2 scan codes, with one shared typematic repeater.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_tracker #(
  parameter int                      NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES     = {9'h075, 9'h072, 9'h06B, 9'h074},
  parameter logic [NUM_KEYS-1:0]     TOGGLE_MASK   = '0,
  parameter int                      REPEAT_DELAY  = 8,
  parameter int                      REPEAT_PERIOD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                been_ready,
  input  logic [8:0]          last_change,
  input  logic [511:0]        key_down,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] toggled,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_held
);

  localparam int c_max_cnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_cnt_w   = $clog2(c_max_cnt) + 1;
  localparam int c_idx_w   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [c_cnt_w-1:0] c_delay  = c_cnt_w'(REPEAT_DELAY);
  localparam logic [c_cnt_w-1:0] c_period = c_cnt_w'(REPEAT_PERIOD);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RATE  = 2'd2
  } state_t;

  // Registered state
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] toggled_q, toggled_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_idx_w-1:0]  rpt_idx_q, rpt_idx_d;

  // Combinational decode
  logic                w_hit;
  logic [c_idx_w-1:0]  w_hit_idx;
  logic [NUM_KEYS-1:0] w_sel;
  logic                w_new_state;
  logic                w_press_ev;
  logic                w_release_ev;
  logic                w_fire;

  // Scan downwards so the lowest matching slot is the one that sticks.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_sel     = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (last_change == KEY_CODES[9*i +: 9]) begin
        w_hit     = 1'b1;
        w_hit_idx = c_idx_w'(i);
        w_sel     = '0;
        w_sel[i]  = 1'b1;
      end
    end
    w_new_state  = key_down[last_change];
    w_press_ev   = been_ready & w_hit & ~held_q[w_hit_idx] &  w_new_state;
    w_release_ev = been_ready & w_hit &  held_q[w_hit_idx] & ~w_new_state;
  end

  always_comb begin
    press_d   = w_sel & {NUM_KEYS{w_press_ev}};
    release_d = w_sel & {NUM_KEYS{w_release_ev}};
    held_d    = (held_q | press_d) & ~release_d;
    toggled_d = toggled_q ^ (press_d & TOGGLE_MASK);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_idx_d = rpt_idx_q;
    w_fire    = 1'b0;
    repeat_d  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
      end
      ST_DELAY: begin
        if (cnt_q == c_delay) begin
          w_fire  = 1'b1;
          cnt_d   = c_one;
          state_d = ST_RATE;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      ST_RATE: begin
        if (cnt_q == c_period) begin
          w_fire = 1'b1;
          cnt_d  = c_one;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Releasing the repeating key cancels any pulse due at the same edge.
    if (w_release_ev && (w_hit_idx == rpt_idx_q) && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      w_fire  = 1'b0;
    end

    // A fresh press always takes over the repeater, even on a due edge.
    if (w_press_ev && (REPEAT_DELAY > 0)) begin
      state_d   = ST_DELAY;
      cnt_d     = c_one;
      rpt_idx_d = w_hit_idx;
      w_fire    = 1'b0;
    end

    if (w_fire) begin
      repeat_d[rpt_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= '0;
      toggled_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rpt_idx_q <= '0;
    end else begin
      held_q    <= held_d;
      toggled_q <= toggled_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_idx_q <= rpt_idx_d;
    end
  end

  assign held          = held_q;
  assign toggled       = toggled_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign any_held      = |held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_tracker
// Description : Scoreboard bench for key_event_tracker; two builds share the
//               key inputs but have separate been_ready strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_tracker;

  typedef struct packed {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
    logic [3:0] hd;
    logic [3:0] tg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         br1 = 1'b0;
  logic         br2 = 1'b0;
  logic [8:0]   lc  = '0;
  logic [511:0] kd  = '0;

  logic [3:0] held1, tog1, pr1, rl1, rp1;
  logic [3:0] held2, tog2, pr2, rl2, rp2;
  logic       ah1, ah2;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q1[$];
  exp_t q2[$];

  key_event_tracker #(
    .NUM_KEYS(4), .KEY_CODES({9'h075, 9'h072, 9'h06B, 9'h074}),
    .TOGGLE_MASK(4'b0000), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .been_ready(br1), .last_change(lc), .key_down(kd),
    .held(held1), .toggled(tog1), .press_pulse(pr1), .release_pulse(rl1),
    .repeat_pulse(rp1), .any_held(ah1)
  );

  key_event_tracker #(
    .NUM_KEYS(4), .KEY_CODES({9'h075, 9'h074, 9'h06B, 9'h074}),
    .TOGGLE_MASK(4'b0010), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) u_dut2 (
    .clk(clk), .rst(rst), .been_ready(br2), .last_change(lc), .key_down(kd),
    .held(held2), .toggled(tog2), .press_pulse(pr2), .release_pulse(rl2),
    .repeat_pulse(rp2), .any_held(ah2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void push(input int d, input int c, input logic [3:0] pr, input logic [3:0] rl,
                               input logic [3:0] rp, input logic [3:0] hd, input logic [3:0] tg);
    exp_t e;
    e = '{cyc: c, pr: pr, rl: rl, rp: rp, hd: hd, tg: tg};
    if (d == 1) q1.push_back(e);
    else        q2.push_back(e);
  endfunction

  task automatic check_ev(input int d, input exp_t got);
    exp_t e;
    bit   empty;
    n_tests++;
    e     = '0;
    empty = (d == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (!empty) e = (d == 1) ? q1.pop_front() : q2.pop_front();
    if (empty) begin
      n_fail++;
      $display("FAIL dut%0d unexpected_event cyc=%0d got pr=%b rl=%b rp=%b held=%b tog=%b, expected no event",
               d, got.cyc, got.pr, got.rl, got.rp, got.hd, got.tg);
    end else if (got != e) begin
      n_fail++;
      $display("FAIL dut%0d event got cyc=%0d pr=%b rl=%b rp=%b held=%b tog=%b, expected cyc=%0d pr=%b rl=%b rp=%b held=%b tog=%b",
               d, got.cyc, got.pr, got.rl, got.rp, got.hd, got.tg,
               e.cyc, e.pr, e.rl, e.rp, e.hd, e.tg);
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Monitors: any pulse on a DUT pops the next expected event.
  always @(negedge clk) begin
    if (!rst && ((pr1 | rl1 | rp1) != 4'b0))
      check_ev(1, '{cyc: cyc, pr: pr1, rl: rl1, rp: rp1, hd: held1, tg: tog1});
    if (!rst && ((pr2 | rl2 | rp2) != 4'b0))
      check_ev(2, '{cyc: cyc, pr: pr2, rl: rl2, rp: rp2, hd: held2, tg: tog2});
  end

  task automatic ev(input int d, input logic [8:0] code, input logic down);
    kd[code] = down;
    lc       = code;
    if (d == 1) br1 = 1'b1;
    else        br2 = 1'b1;
    @(negedge clk);
    br1 = 1'b0;
    br2 = 1'b0;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #1 rst = 1'b1;
    #11;
    chk("reset_held",    held1, 4'b0000);
    chk("reset_toggled", tog1,  4'b0000);
    chk("reset_press",   pr1,   4'b0000);
    chk("reset_release", rl1,   4'b0000);
    chk("reset_repeat",  rp1,   4'b0000);
    chk("reset_any",     {3'b0, ah1}, 4'b0000);
    chk("reset_held2",   held2, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Press/release UP with a redundant update; repeats run while held.
    s = cyc;
    push(1, s+1,  4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    push(1, s+9,  4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    push(1, s+12, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    push(1, s+15, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    push(1, s+18, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    push(1, s+21, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    ev(1, 9'h075, 1'b1);
    at_cycle(s+3);
    chk("any_held_up", {3'b0, ah1}, 4'b0001);
    at_cycle(s+10); ev(1, 9'h075, 1'b1);
    at_cycle(s+20); ev(1, 9'h075, 1'b0);
    at_cycle(s+26);

    // Auto-repeat on RIGHT, release on the next due edge.
    s = cyc;
    push(1, s+1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push(1, s+9,  4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    push(1, s+12, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    push(1, s+15, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    push(1, s+18, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    ev(1, 9'h074, 1'b1);
    at_cycle(s+17); ev(1, 9'h074, 0);
    at_cycle(s+24);

    // Pre-emption: DOWN pressed on LEFT's due edge takes over the repeater.
    s = cyc;
    push(1, s+1,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    push(1, s+9,  4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    push(1, s+12, 4'b0100, 4'b0000, 4'b0000, 4'b0110, 4'b0000);
    push(1, s+20, 4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0000);
    push(1, s+23, 4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0000);
    push(1, s+25, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    push(1, s+31, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    ev(1, 9'h06B, 1'b1);
    at_cycle(s+11); ev(1, 9'h072, 1'b1);
    at_cycle(s+24); ev(1, 9'h072, 1'b0);
    at_cycle(s+30); ev(1, 9'h06B, 1'b0);
    at_cycle(s+36);

    // Asynchronous reset mid-delay with LEFT and UP held.
    s = cyc;
    push(1, s+1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    push(1, s+3, 4'b1000, 4'b0000, 4'b0000, 4'b1010, 4'b0000);
    ev(1, 9'h06B, 1'b1);
    at_cycle(s+2); ev(1, 9'h075, 1'b1);
    at_cycle(s+4);
    chk("pre_reset_held", held1, 4'b1010);
    #2 rst = 1'b1;
    #1;
    chk("async_held",    held1, 4'b0000);
    chk("async_any",     {3'b0, ah1}, 4'b0000);
    chk("async_press",   pr1,   4'b0000);
    chk("async_repeat",  rp1,   4'b0000);
    repeat (2) @(negedge clk);
    kd  = '0;
    rst = 1'b0;
    @(negedge clk);
    s = cyc;
    ev(1, 9'h01A, 1'b1);
    at_cycle(s+3);
    chk("unmapped_held", held1, 4'b0000);
    chk("unmapped_any",  {3'b0, ah1}, 4'b0000);
    ev(1, 9'h01A, 1'b0);
    at_cycle(s+20);
    chk("no_late_repeat_held", held1, 4'b0000);

    // Toggle slot, duplicate codes and repeat-disabled build.
    s = cyc;
    push(2, s+1,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    push(2, s+4,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    push(2, s+7,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    push(2, s+10, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    push(2, s+13, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    push(2, s+16, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    push(2, s+19, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0010);
    push(2, s+36, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
    ev(2, 9'h06B, 1'b1);
    at_cycle(s+3);  ev(2, 9'h06B, 1'b0);
    at_cycle(s+6);  ev(2, 9'h06B, 1'b1);
    at_cycle(s+9);  ev(2, 9'h06B, 1'b0);
    at_cycle(s+12); ev(2, 9'h06B, 1'b1);
    at_cycle(s+15); ev(2, 9'h06B, 1'b0);
    at_cycle(s+18); ev(2, 9'h074, 1'b1);
    at_cycle(s+30);
    chk("dup_held2", held2, 4'b0001);
    at_cycle(s+35); ev(2, 9'h074, 1'b0);
    at_cycle(s+42);
    chk("final_tog2", tog2, 4'b0010);

    n_tests++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL dut1 missing_events got=%0d pending expected=0", q1.size());
    end
    n_tests++;
    if (q2.size() != 0) begin
      n_fail++;
      $display("FAIL dut2 missing_events got=%0d pending expected=0", q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_event_tracker.md
Name: key_event_tracker

Overview:
- Parametrised successor to the fixed four-arrow key-state decoder.
- Sits between the PS/2 keyboard front-end (been_ready / last_change / key_down) and game/control logic.
- Tracks hold state for NUM_KEYS configurable scan codes, with per-key one-cycle press and release pulses.
- Adds per-key toggle mode and a single shared typematic auto-repeat engine for the most recently pressed key.

Parameters:
- NUM_KEYS, 4, number of tracked key slots (1..16).
- KEY_CODES, {9'h075,9'h072,9'h06B,9'h074}, packed NUM_KEYS*9 bits; slot i = bits [9i+8:9i]. Default slot0=RIGHT, 1=LEFT, 2=DOWN, 3=UP.
- TOGGLE_MASK, 0, bit i=1 puts slot i in toggle mode.
- REPEAT_DELAY, 8, cycles from press pulse to first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 3, cycles between subsequent repeat pulses (must be >=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- been_ready  in  1  one-cycle strobe: last_change/key_down valid.
- last_change  in  9  scan code of most recent make/break ({E0 flag, code}).
- key_down  in  512  current down-state of every scan code.
- held  out  NUM_KEYS  registered level: key currently down.
- toggled  out  NUM_KEYS  toggle state; flips on press of slots in TOGGLE_MASK, otherwise 0.
- press_pulse  out  NUM_KEYS  one-cycle pulse on 0->1 of held[i].
- release_pulse  out  NUM_KEYS  one-cycle pulse on 1->0 of held[i].
- repeat_pulse  out  NUM_KEYS  one-cycle typematic pulse for the repeating slot.
- any_held  out  1  OR of held.

Behaviour:
- Reset: all outputs 0, repeat FSM in IDLE, counter 0. Async assert clears everything immediately, including mid-repeat. Release is synchronous to clk.
- Matching: when been_ready=1 in cycle t, compare last_change with every slot. The lowest matching index wins. No match: no state change.
- Update: new_state = key_down[last_change]. held[i] takes new_state at edge t+1, so latency is 1 cycle.
- Pulses:
  - press_pulse[i]=1 during cycle t+1 only if held[i] was 0 and new_state=1.
  - release_pulse[i] likewise for 1->0.
  - Redundant updates (same state) produce no pulse.
- Pulse outputs are 0 in every cycle without a qualifying event. At most one slot changes per cycle.
- Toggle: on press of slot i with TOGGLE_MASK[i]=1, toggled[i] inverts in the same cycle as press_pulse. Releases do not affect it.
- Repeat FSM states: IDLE, DELAY, RATE; registers rpt_idx and cnt (width clog2(max(REPEAT_DELAY, REPEAT_PERIOD))+1).
  - Any press of slot i (REPEAT_DELAY>0): rpt_idx<=i, cnt<=1, state<=DELAY. A new press pre-empts the current repeat key.
  - DELAY: cnt increments each cycle. When cnt==REPEAT_DELAY: repeat_pulse[rpt_idx]=1 that cycle, cnt<=1, state<=RATE. First repeat lands REPEAT_DELAY cycles after the press pulse.
  - RATE: when cnt==REPEAT_PERIOD: pulse and cnt<=1, else increment.
  - Release of rpt_idx (registered at the same edge) -> IDLE. A repeat pulse due in that cycle is suppressed.
  - Release of any other slot: no effect on the FSM.
  - A press registered at the same edge a repeat would fire: the press wins and the old key gets no pulse.
- repeat_pulse is only ever asserted while held[rpt_idx]=1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert rst mid-run with held=4'b1010 -> all outputs 0 immediately. After release, been_ready pulses for unmapped code 9'h01A -> outputs stay 0.
- Press/release: been_ready with last_change=9'h075, key_down[9'h075]=1 at cycle 10 -> held=4'b1000 and press_pulse=4'b1000 at cycle 11 only. Repeating the same event at cycle 20 -> no pulse. key_down=0 at cycle 30 -> release_pulse=4'b1000 at 31, held=0.
- Auto-repeat (DELAY=8, PERIOD=3): press RIGHT (9'h074), pulse at cycle 11 -> repeat_pulse=4'b0001 at cycles 19, 22, 25. Release registered at cycle 28 (the next due cycle) -> no pulse at 28 or later.
- Pre-emption: hold LEFT repeating, press DOWN at pulse cycle 15 -> repeats switch to 4'b0100 from cycle 23. LEFT still held; no further LEFT repeats.
- Toggle: TOGGLE_MASK=4'b0010, press/release LEFT three times -> toggled[1] sequence 1, 0, 1. Toggles change only on press cycles.
- Duplicate codes: KEY_CODES slots 0 and 2 both 9'h074 -> only slot 0 updates. REPEAT_DELAY=0 build -> repeat_pulse never asserts.
